// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction prefetch path.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// In-order queue of {pc, instr} pairs between the memory response path and fetch.
module prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (o_count == '0);
  assign o_full    = (o_count == (AW+1)'(DEPTH));
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty && !i_clear;
  // A push into a full queue is legal when the head leaves in the same cycle.
  assign w_do_push = i_push && !i_clear && (!o_full || w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Credit-based instruction prefetcher: issues word fetches, queues responses, flushes on redirect.
module instr_prefetch_unit #(
  parameter int              XLEN            = riscv_pkg::XLEN,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  output logic                     imem_req_o,
  output logic [XLEN-1:0]          imem_addr_o,
  input  logic                     imem_gnt_i,
  input  logic                     imem_rvalid_i,
  input  logic [XLEN-1:0]          imem_rdata_i,
  input  logic                     instr_ready_i,
  output logic                     instr_valid_o,
  output logic [XLEN-1:0]          instr_o,
  output logic [XLEN-1:0]          pc_o,
  output logic [XLEN-1:0]          pc_plus4_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  import riscv_pkg::*;

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0]   r_fetch_pc;
  logic [XLEN-1:0]   r_rsp_pc;
  logic [OW-1:0]     r_outstanding;
  logic [OW-1:0]     r_drop;
  logic [31:0]       w_credit_used;
  logic              w_gnt;
  logic              w_rsp;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic [2*XLEN-1:0] w_head;
  logic [XLEN-1:0]   w_redirect_pc;

  // Responses still owed to the queue: stale (dropped) responses need no slot.
  assign w_credit_used = 32'(count_o) + 32'(r_outstanding) - 32'(r_drop);
  // NOTE: req is gated by the async reset so it reads 0 while reset is held.
  assign imem_req_o    = rst && !redirect_i &&
                         (32'(r_outstanding) < 32'(MAX_OUTSTANDING)) &&
                         (w_credit_used < 32'(DEPTH));
  assign imem_addr_o   = r_fetch_pc;
  assign w_gnt         = imem_req_o && imem_gnt_i;
  assign w_rsp         = imem_rvalid_i && (r_outstanding != '0);
  assign w_push        = w_rsp && (r_drop == '0) && !redirect_i;
  assign w_pop         = instr_valid_o && instr_ready_i;
  assign w_redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (redirect_i) begin
      r_fetch_pc    <= w_redirect_pc;
      r_rsp_pc      <= w_redirect_pc;
      r_outstanding <= r_outstanding - OW'(w_rsp);
      r_drop        <= r_outstanding - OW'(w_rsp);
    end else begin
      if (w_gnt) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      r_outstanding <= r_outstanding + OW'(w_gnt) - OW'(w_rsp);
      if (w_rsp) begin
        if (r_drop != '0) r_drop   <= r_drop - 1'b1;
        else              r_rsp_pc <= r_rsp_pc + XLEN'(4);
      end
    end
  end

  prefetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (redirect_i),
    .i_data  ({r_rsp_pc, imem_rdata_i}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count_o)
  );

  assign instr_valid_o = !w_empty;
  assign pc_o          = instr_valid_o ? w_head[2*XLEN-1:XLEN] : r_rsp_pc;
  assign instr_o       = instr_valid_o ? w_head[XLEN-1:0] : XLEN'(NOP_INSTR);
  assign pc_plus4_o    = pc_o + XLEN'(4);

  a_gnt_needs_req : assert property (@(posedge clk) disable iff (!rst) imem_gnt_i |-> imem_req_o);
  a_rsp_needs_out : assert property (@(posedge clk) disable iff (!rst) imem_rvalid_i |-> (r_outstanding != '0));
  a_no_overflow   : assert property (@(posedge clk) disable iff (!rst) w_push |-> (!w_full || w_pop));

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench: randomized memory/stall/redirect traffic against a queue-based delivery model.
module tb_instr_prefetch_unit;
  import riscv_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_ready_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [2:0]  count_o;

  instr_prefetch_unit #(
    .XLEN (32), .DEPTH (DEPTH), .MAX_OUTSTANDING (MAXO), .RESET_PC (32'h0)
  ) dut (
    .clk (clk), .rst (rst),
    .redirect_i (redirect_i), .redirect_pc_i (redirect_pc_i),
    .imem_req_o (imem_req_o), .imem_addr_o (imem_addr_o),
    .imem_gnt_i (imem_gnt_i), .imem_rvalid_i (imem_rvalid_i), .imem_rdata_i (imem_rdata_i),
    .instr_ready_i (instr_ready_i), .instr_valid_o (instr_valid_o),
    .instr_o (instr_o), .pc_o (pc_o), .pc_plus4_o (pc_plus4_o), .count_o (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_rec_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  int           lat    = 1;
  int           gnt_pct = 100;
  int           epoch  = 0;
  logic [31:0]  exp_fetch_pc = 32'h0;
  req_rec_t     inflight[$];
  fetch_entry_t q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  function automatic logic rsp_due();
    return (inflight.size() > 0) && (inflight[0].due <= cyc);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_req"},   {31'b0, imem_req_o},    32'd0);
    check({tag, "_addr"},  imem_addr_o,            32'h0);
    check({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd0);
    check({tag, "_instr"}, instr_o,                NOP_INSTR);
    check({tag, "_pc"},    pc_o,                   32'h0);
    check({tag, "_pc4"},   pc_plus4_o,             32'h4);
    check({tag, "_count"}, {29'b0, count_o},       32'd0);
  endtask

  // One clock cycle; entered and left at posedge+1.
  task automatic step(input logic redir, input logic [31:0] tgt, input logic rdy);
    logic     do_rsp;
    logic     gnt_s;
    logic     pop_s;
    logic     exp_req;
    int       live;
    req_rec_t rec;
    do_rsp        = rsp_due();
    redirect_i    = redir;
    redirect_pc_i = tgt;
    instr_ready_i = rdy;
    imem_rvalid_i = do_rsp;
    imem_rdata_i  = do_rsp ? mem_word(inflight[0].addr) : $urandom;
    #1;
    imem_gnt_i    = imem_req_o && ($urandom_range(99) < gnt_pct);
    @(negedge clk);
    live = 0;
    foreach (inflight[i]) if (inflight[i].epoch == epoch) live++;
    exp_req = !redir && (inflight.size() < MAXO) && (q.size() + live < DEPTH);
    check("req",   {31'b0, imem_req_o},    {31'b0, exp_req});
    check("addr",  imem_addr_o,            exp_fetch_pc);
    check("count", {29'b0, count_o},       32'(q.size()));
    check("valid", {31'b0, instr_valid_o}, {31'b0, q.size() != 0});
    check("outstanding_le_max", {31'b0, inflight.size() <= MAXO}, 32'd1);
    if (q.size() != 0) begin
      check("head_pc",    pc_o,       q[0].pc);
      check("head_instr", instr_o,    q[0].instr);
      check("head_pc4",   pc_plus4_o, q[0].pc + 32'd4);
    end else begin
      check("idle_nop", instr_o, NOP_INSTR);
    end
    gnt_s = imem_req_o && imem_gnt_i;
    pop_s = instr_valid_o && instr_ready_i;
    @(posedge clk);
    #1;
    if (pop_s && !redir && q.size() != 0) void'(q.pop_front());
    if (do_rsp) begin
      rec = inflight.pop_front();
      if (!redir && rec.epoch == epoch) q.push_back('{pc: rec.addr, instr: mem_word(rec.addr)});
    end
    if (gnt_s) begin
      inflight.push_back('{addr: exp_fetch_pc, epoch: epoch, due: cyc + lat});
      exp_fetch_pc += 32'd4;
    end
    if (redir) begin
      q.delete();
      epoch++;
      exp_fetch_pc = {tgt[31:2], 2'b00};
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_check("por");
    rst = 1'b1;

    // Zero-wait memory, fetch always ready.
    repeat (30) step(1'b0, 32'h0, 1'b1);

    // Fetch stalled: queue fills, requests stop.
    repeat (10) step(1'b0, 32'h0, 1'b0);
    check("stall_full",  {29'b0, count_o},    32'd4);
    check("stall_noreq", {31'b0, imem_req_o}, 32'd0);
    repeat (20) step(1'b0, 32'h0, 1'b1);

    // Three-cycle response latency.
    lat = 3;
    repeat (40) step(1'b0, 32'h0, 1'b1);

    // Redirect with two requests in flight.
    for (int i = 0; i < 20 && !(inflight.size() == 2 && !rsp_due()); i++) step(1'b0, 32'h0, 1'b1);
    check("redir_setup", 32'(inflight.size()), 32'd2);
    step(1'b1, 32'h0000_0100, 1'b1);
    check("redir_count0", {29'b0, count_o},       32'd0);
    check("redir_valid0", {31'b0, instr_valid_o}, 32'd0);
    repeat (20) step(1'b0, 32'h0, 1'b1);

    // Redirect in the same cycle as a response, misaligned target.
    lat = 1;
    repeat (5) step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 20 && !rsp_due(); i++) step(1'b0, 32'h0, 1'b1);
    check("coinc_setup", {31'b0, rsp_due()}, 32'd1);
    step(1'b1, 32'h0000_0202, 1'b1);
    check("coinc_addr", imem_addr_o, 32'h0000_0200);
    repeat (20) step(1'b0, 32'h0, 1'b1);

    // Randomized latency, grant, stall and redirect traffic.
    gnt_pct = 70;
    for (int i = 0; i < 500; i++) begin
      if (i % 25 == 0) lat = $urandom_range(4, 1);
      step($urandom_range(99) < 4, $urandom, $urandom_range(99) < 70);
    end

    // Reset in the middle of traffic.
    gnt_pct = 100;
    lat     = 3;
    repeat (6) step(1'b0, 32'h0, 1'b0);
    rst = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; redirect_i = 1'b0;
    #1;
    reset_check("midreset");
    q.delete();
    inflight.delete();
    epoch++;
    exp_fetch_pc = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (30) step(1'b0, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_unit.md
Name: instr_prefetch_unit

Overview:
- Upstream neighbour of the fetch stage.
- Issues word fetches to instruction memory over a req/gnt/rvalid handshake that tolerates variable latency.
- Buffers returned {pc, instr} pairs in a small in-order queue and hands them to fetch with valid/ready.
- On a taken branch/jump redirect from the memory stage (PCSrcM/PCTargetM), flushes the queue and discards in-flight responses.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 4, prefetch queue entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect_i  in  1  branch/jump taken (driven from PCSrcM).
- redirect_pc_i  in  XLEN  redirect target (PCTargetM).
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  XLEN  word address of request.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid (in request order).
- imem_rdata_i  in  XLEN  response instruction.
- instr_ready_i  in  1  fetch stage can accept (driven by !stall).
- instr_valid_o  out  1  queue head valid.
- instr_o  out  XLEN  head instruction; NOP 32'h0000_0013 when not valid.
- pc_o  out  XLEN  head PC.
- pc_plus4_o  out  XLEN  pc_o + 4.
- count_o  out  $clog2(DEPTH)+1  queue occupancy.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc = rsp_pc = RESET_PC; queue empty; outstanding = 0; drop = 0.
  - Outputs: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=NOP, pc_o=RESET_PC, pc_plus4_o=RESET_PC+4, count_o=0.
  - Reset mid-transfer abandons all in-flight requests. The memory model is reset together with this block.
- Credit rule:
  - imem_req_o=1 iff !redirect_i and outstanding < MAX_OUTSTANDING and (count + outstanding − drop) < DEPTH.
  - Every accepted response therefore has a free queue slot; the queue never overflows.
- Request hold: once asserted, imem_req_o stays high with imem_addr_o=fetch_pc stable until gnt. Redirect is the only exception (req may drop, addr changes).
- On req&gnt: fetch_pc += 4 (wraps modulo 2^XLEN); outstanding += 1.
- On rvalid: outstanding −= 1.
  - If drop>0: drop −= 1, data discarded.
  - Else: push {rsp_pc, rdata}; rsp_pc += 4.
- Pop when instr_valid_o & instr_ready_i. Push and pop in the same cycle are allowed, including when full, since credit guarantees push only when space exists after the pop.
- Head outputs are combinational from the queue head. Latency: rvalid at cycle N → instr_valid_o at cycle N+1 when the queue was empty. No bypass.
- Redirect (redirect_i=1, single cycle):
  - Queue cleared.
  - fetch_pc = rsp_pc = {redirect_pc_i[XLEN-1:2], 2'b00}; misaligned low bits are forced to 0.
  - drop = outstanding after this cycle's rvalid decrement. A response arriving in the redirect cycle is discarded.
  - No gnt can occur in the redirect cycle, because req=0.
  - instr_valid_o=0 in the cycle after redirect.
- instr_valid_o may be 1 during a redirect cycle; a pop in that cycle is ignored by fetch, which flushes.
- instr_ready_i=0 holds head outputs stable. Issuing continues until credits are exhausted.
- imem_gnt_i without a request, or imem_rvalid_i with outstanding=0: protocol error. Ignored; assertion in simulation.

Decomposition:
- riscv_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - XLEN.
  - typedef fetch_entry_t {pc, instr}.
- One sub-module: prefetch_fifo.
  - Synchronous FIFO, width 2×XLEN, depth DEPTH.
  - Ports: push, pop, clear, full, empty, count.
  - Asynchronous active-low reset.

Test Plan:
- Zero-wait memory (gnt=1 always, rvalid 1 cycle after gnt), instr_ready_i=1 → pc_o sequence 0,4,8,…; instr_valid_o continuous after startup; instr_o matches memory words.
- instr_ready_i=0 for 10 cycles with 1-cycle memory → count_o saturates at 4; imem_req_o=0 once count+outstanding=4; head pc_o=0 held stable; release → pcs 0,4,8,12,16 in order with no loss.
- 3-cycle response latency, MAX_OUTSTANDING=2 → never more than 2 gnts ahead of rvalids; no duplicate or skipped PCs.
- Redirect to 32'h0000_0100 with 2 requests outstanding → both responses dropped; next instr_valid_o has pc_o=0x100, pc_plus4_o=0x104; count_o=0 the cycle after redirect.
- Redirect coincident with rvalid, target 32'h0000_0202 → that response discarded; fetch resumes at 0x200.
- Assert rst low while outstanding=2 and the queue holds 3 entries → all outputs immediately at reset values; after release, fetch restarts at RESET_PC.
